// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and result register wrapped around an external combinational 3-bit ALU.
// Commands queue in order, the head drives the ALU, and results leave over a valid/ready handshake.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_a,
  input  logic [2:0]              cmd_b,
  input  logic [1:0]              cmd_op,
  output logic [2:0]              alu_a,
  output logic [2:0]              alu_b,
  output logic [1:0]              alu_opcode,
  input  logic [3:0]              alu_z,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [3:0]              res_z,
  output logic [1:0]              res_op,
  output logic                    res_zero,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [CNT_W-1:0]        res_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] op;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             push;
  logic             issue;
  logic             xfer;

  // Handshake qualifiers, all derived from registered state
  assign empty     = (fifo_level == '0);
  assign cmd_ready = (fifo_level < LVL_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign issue     = !empty && (!res_valid || res_ready);
  assign xfer      = res_valid && res_ready;

  // Head entry feeds the ALU directly; zeros when nothing is queued
  assign head       = mem[rd_ptr];
  assign alu_a      = empty ? 3'd0 : head.a;
  assign alu_b      = empty ? 3'd0 : head.b;
  assign alu_opcode = empty ? 2'd0 : head.op;

  // Storage carries no reset; validity is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_t'({cmd_a, cmd_b, cmd_op});
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, issue})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Result slot: reload on issue (even while a transfer happens), else drain on transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_z     <= 4'd0;
      res_op    <= 2'd0;
      res_zero  <= 1'b0;
    end else if (issue) begin
      res_valid <= 1'b1;
      res_z     <= alu_z;
      res_op    <= head.op;
      res_zero  <= (alu_z == 4'd0);
    end else if (xfer) begin
      res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_count <= '0;
    end else if (xfer) begin
      res_count <= res_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural stand-in for the 3-bit ALU.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_a;
  logic [2:0] cmd_b;
  logic [1:0] cmd_op;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic [1:0] alu_opcode;
  logic [3:0] alu_z;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_z;
  logic [1:0] res_op;
  logic       res_zero;
  logic [2:0] fifo_level;
  logic [7:0] res_count;

  typedef struct {
    logic [3:0] z;
    logic [1:0] op;
    logic       zero;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;
  int         max_lvl = 0;
  bit         chk_lvl2 = 1'b0;

  alu_cmd_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_op(res_op), .res_zero(res_zero),
    .fifo_level(fifo_level), .res_count(res_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the external ALU
  always_comb begin
    case (alu_opcode)
      2'b00:   alu_z = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_z = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   alu_z = {1'b0, alu_a & alu_b};
      default: alu_z = {1'b0, alu_a | alu_b};
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one command and hold it until accepted; expected result queued at acceptance
  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                      input logic [3:0] z);
    bit   ok = 1'b0;
    exp_t e;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        e.z = z; e.op = op; e.zero = (z == 4'd0);
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !res_valid) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: compares every transferred result and tracks the expected result count
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_cnt = 8'd0;
      end else begin
        chk("res_count", 32'(res_count), 32'(exp_cnt));
        if (chk_lvl2) chk("level_hold_2", 32'(fifo_level), 32'd2);
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        if (res_valid && res_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 32'(res_z), 32'hDEAD);
          end else begin
            e = q.pop_front();
            chk("res_z", 32'(res_z), 32'(e.z));
            chk("res_op", 32'(res_op), 32'(e.op));
            chk("res_zero", 32'(res_zero), 32'(e.zero));
          end
          exp_cnt = exp_cnt + 8'd1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = 3'd0; cmd_b = 3'd0; cmd_op = 2'd0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_z", 32'(res_z), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_count", 32'(res_count), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    rst = 1'b0;

    // Single command: one-cycle latency from acceptance
    res_ready = 1'b1;
    send(3'd7, 3'd7, 2'b00, 4'hE);
    chk("lat_head_a", 32'(alu_a), 32'd7);
    chk("lat_level", 32'(fifo_level), 32'd1);
    chk("lat_not_yet", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", 32'(res_valid), 32'd1);
    chk("lat_z", 32'(res_z), 32'hE);
    @(posedge clk); #1;
    chk("lat_count", 32'(res_count), 32'd1);
    chk("lat_empty", 32'(res_valid), 32'd0);

    // Back-to-back stream with downstream always ready
    max_lvl = 0;
    send(3'd1, 3'd2, 2'b01, 4'hF);
    send(3'd5, 3'd3, 2'b10, 4'h1);
    send(3'd4, 3'd2, 2'b11, 4'h6);
    send(3'd3, 3'd3, 2'b01, 4'h0);
    chk("stream_z3", 32'(res_z), 32'h6);
    @(posedge clk); #1;
    chk("stream_z4", 32'(res_z), 32'h0);
    chk("stream_zero4", 32'(res_zero), 32'd1);
    @(posedge clk); #1;
    chk("stream_done", 32'(res_valid), 32'd0);
    chk("stream_max_level", 32'(max_lvl), 32'd1);

    // Backpressure: DEPTH+1 outstanding, then the sixth offer is refused
    res_ready = 1'b0;
    send(3'd1, 3'd1, 2'b00, 4'h2);
    send(3'd6, 3'd3, 2'b01, 4'h3);
    send(3'd7, 3'd5, 2'b10, 4'h5);
    send(3'd2, 3'd4, 2'b11, 4'h6);
    send(3'd5, 3'd7, 2'b00, 4'hC);
    cmd_a = 3'd3; cmd_b = 3'd3; cmd_op = 2'b00; cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("full_level", 32'(fifo_level), 32'd4);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_z", 32'(res_z), 32'h2);
      chk("hold_op", 32'(res_op), 32'd0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("drain5_queue", 32'(q.size()), 32'd0);
    chk("drain5_valid", 32'(res_valid), 32'd0);
    chk("drain5_level", 32'(fifo_level), 32'd0);

    // Level held at 2 with simultaneous push and pop across pointer wrap
    res_ready = 1'b0;
    send(3'd1, 3'd0, 2'b00, 4'h1);
    send(3'd2, 3'd0, 2'b00, 4'h2);
    send(3'd3, 3'd0, 2'b00, 4'h3);
    chk("lvl2_start", 32'(fifo_level), 32'd2);
    res_ready = 1'b1;
    chk_lvl2 = 1'b1;
    send(3'd4, 3'd1, 2'b00, 4'h5);
    send(3'd7, 3'd2, 2'b01, 4'h5);
    send(3'd6, 3'd3, 2'b10, 4'h2);
    send(3'd1, 3'd4, 2'b11, 4'h5);
    send(3'd0, 3'd1, 2'b01, 4'hF);
    send(3'd5, 3'd5, 2'b10, 4'h5);
    send(3'd3, 3'd4, 2'b00, 4'h7);
    send(3'd2, 3'd5, 2'b11, 4'h7);
    chk_lvl2 = 1'b0;
    wait_drain();

    // Asynchronous reset mid-stream discards everything
    res_ready = 1'b0;
    send(3'd1, 3'd2, 2'b00, 4'h3);
    send(3'd2, 3'd2, 2'b00, 4'h4);
    send(3'd3, 3'd2, 2'b00, 4'h5);
    send(3'd4, 3'd2, 2'b00, 4'h6);
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    chk("pre_rst_valid", 32'(res_valid), 32'd1);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_z", 32'(res_z), 32'd0);
    chk("arst_op", 32'(res_op), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_count", 32'(res_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    send(3'd2, 3'd1, 2'b00, 4'h3);
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(res_valid), 32'd1);
    chk("post_rst_z", 32'(res_z), 32'h3);
    wait_drain();
    chk("post_rst_count", 32'(res_count), 32'd1);

    // Result counter wraps after 256 transfers
    do_reset();
    res_ready = 1'b1;
    repeat (256) send(3'd1, 3'd1, 2'b00, 4'h2);
    wait_drain();
    chk("count_wrap", 32'(res_count), 32'd0);
    send(3'd1, 3'd1, 2'b00, 4'h2);
    wait_drain();
    chk("count_257", 32'(res_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
